// File: rtl/bsg_link_sdr_downstream_ch.sv
// Receive end of the SDR link channel: phits are assembled into core words,
// queued in a small FIFO, and credit is returned as a toggle-encoded token.
module bsg_link_sdr_downstream_ch #(
   parameter int channel_width_p                 = 8,
   parameter int core_width_p                    = 32,
   parameter int lg_fifo_depth_p                 = 3,
   parameter int lg_credit_to_token_decimation_p = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       io_valid_i,
   input  logic [channel_width_p-1:0] io_data_i,
   output logic                       core_valid_o,
   output logic [core_width_p-1:0]    core_data_o,
   input  logic                       core_ready_i,
   output logic                       io_token_r_o,
   output logic [lg_fifo_depth_p:0]   occupancy_o,
   output logic                       overflow_o
);

   localparam int ppw_lp   = core_width_p / channel_width_p;
   localparam int cnt_w_lp = $clog2(ppw_lp);
   localparam int depth_lp = 1 << lg_fifo_depth_p;
   localparam int dec_w_lp = lg_credit_to_token_decimation_p;

   logic [cnt_w_lp-1:0]                   phit_cnt_q, phit_cnt_d;
   logic [ppw_lp-2:0][channel_width_p-1:0] asm_q, asm_d;
   logic [depth_lp-1:0][core_width_p-1:0]  mem_q;
   logic [lg_fifo_depth_p-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
   logic [lg_fifo_depth_p:0]              cnt_q, cnt_d;
   logic [dec_w_lp-1:0]                   dec_q, dec_d;
   logic                                  tok_q, tok_d;
   logic                                  ovf_q, ovf_d;

   logic                    last_phit, push, pop, accept;
   logic [core_width_p-1:0] push_word;

   assign last_phit = (phit_cnt_q == cnt_w_lp'(ppw_lp - 1));
   assign push      = io_valid_i & last_phit;
   assign pop       = core_valid_o & core_ready_i;
   // a pop on the same edge frees a slot, so a full FIFO can still take the word
   assign accept    = push & ((cnt_q < (lg_fifo_depth_p+1)'(depth_lp)) | pop);
   assign push_word = {io_data_i, asm_q};

   always_comb begin
      asm_d = asm_q;
      for (int k = 0; k < ppw_lp - 1; k++)
         if (io_valid_i && phit_cnt_q == cnt_w_lp'(k)) asm_d[k] = io_data_i;

      phit_cnt_d = phit_cnt_q;
      if (io_valid_i) phit_cnt_d = last_phit ? '0 : phit_cnt_q + cnt_w_lp'(1);

      wptr_d = accept ? wptr_q + lg_fifo_depth_p'(1) : wptr_q;
      rptr_d = pop    ? rptr_q + lg_fifo_depth_p'(1) : rptr_q;

      cnt_d = cnt_q;
      if (accept && !pop)      cnt_d = cnt_q + (lg_fifo_depth_p+1)'(1);
      else if (!accept && pop) cnt_d = cnt_q - (lg_fifo_depth_p+1)'(1);

      ovf_d = ovf_q | (push & ~accept);

      dec_d = pop ? dec_q + dec_w_lp'(1) : dec_q;
      tok_d = tok_q ^ (pop & (&dec_q));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phit_cnt_q <= '0;
         asm_q      <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         dec_q      <= '0;
         tok_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         phit_cnt_q <= phit_cnt_d;
         asm_q      <= asm_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
         dec_q      <= dec_d;
         tok_q      <= tok_d;
         ovf_q      <= ovf_d;
      end
   end

   // storage needs no reset: contents are only visible behind a nonzero count
   always_ff @(posedge clk) begin
      if (rst_n && accept) mem_q[wptr_q] <= push_word;
   end

   assign core_valid_o = (cnt_q != '0);
   assign core_data_o  = core_valid_o ? mem_q[rptr_q] : '0;
   assign io_token_r_o = tok_q;
   assign occupancy_o  = cnt_q;
   assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_bsg_link_sdr_downstream_ch.sv
// Scoreboard bench for the link downstream channel: words are queued when sent
// and compared as the core side dequeues them.
module tb_bsg_link_sdr_downstream_ch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        io_valid_i = 1'b0;
   logic [7:0]  io_data_i = '0;
   logic        core_valid_o;
   logic [31:0] core_data_o;
   logic        core_ready_i = 1'b0;
   logic        io_token_r_o;
   logic [3:0]  occupancy_o;
   logic        overflow_o;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   bsg_link_sdr_downstream_ch dut (
      .clk(clk), .rst_n(rst_n),
      .io_valid_i(io_valid_i), .io_data_i(io_data_i),
      .core_valid_o(core_valid_o), .core_data_o(core_data_o), .core_ready_i(core_ready_i),
      .io_token_r_o(io_token_r_o), .occupancy_o(occupancy_o), .overflow_o(overflow_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; io_valid_i = 1'b0; core_ready_i = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int k = 0; k < 4; k++) begin
         io_valid_i = 1'b1;
         io_data_i  = w[k*8 +: 8];
         tick();
         io_valid_i = 1'b0;
         if (k < 3) repeat (gap) tick();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", core_valid_o); end
      total++; if (core_data_o !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", core_data_o); end
      total++; if (io_token_r_o !== 1'b0) begin bad++; $display("FAIL reset_token: got %b want 0", io_token_r_o); end
      total++; if (occupancy_o !== 4'd0) begin bad++; $display("FAIL reset_occ: got %0d want 0", occupancy_o); end
      total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow_o); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [31:0] w = 32'h44332211;
      core_ready_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         io_valid_i = 1'b1;
         io_data_i  = w[k*8 +: 8];
         tick();
         if (k == 2) begin
            total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got %b want 0", core_valid_o); end
         end
      end
      io_valid_i = 1'b0;
      exp_q.push_back(w);
      total++; if (core_valid_o !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", core_valid_o); end
      total++; if (core_data_o !== exp_q[0]) begin bad++; $display("FAIL basic_data: got %h want %h", core_data_o, exp_q[0]); end
      total++; if (occupancy_o !== 4'd1) begin bad++; $display("FAIL basic_occ: got %0d want 1", occupancy_o); end
      core_ready_i = 1'b1;
      void'(exp_q.pop_front());
      tick();
      core_ready_i = 1'b0;
      total++; if (occupancy_o !== 4'd0) begin bad++; $display("FAIL basic_drain_occ: got %0d want 0", occupancy_o); end
      total++; if (core_data_o !== 32'h0) begin bad++; $display("FAIL basic_idle_data: got %h want 0", core_data_o); end
   endtask

   task automatic test_gaps();
      logic [31:0] w = 32'h44332211;
      logic [31:0] e;
      core_ready_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         io_valid_i = 1'b1;
         io_data_i  = w[k*8 +: 8];
         tick();
         io_valid_i = 1'b0;
         io_data_i  = 8'hEE;
         if (k < 3) begin
            tick(); tick();
            total++; if (occupancy_o !== 4'd0) begin bad++; $display("FAIL gaps_occ_mid: got %0d want 0", occupancy_o); end
         end
      end
      exp_q.push_back(w);
      e = exp_q.pop_front();
      total++; if (core_valid_o !== 1'b1) begin bad++; $display("FAIL gaps_valid: got %b want 1", core_valid_o); end
      total++; if (core_data_o !== e) begin bad++; $display("FAIL gaps_data: got %h want %h", core_data_o, e); end
      core_ready_i = 1'b1;
      tick();
      core_ready_i = 1'b0;
   endtask

   task automatic test_overflow();
      logic [31:0] w, e;
      core_ready_i = 1'b0;
      for (int i = 0; i < 9; i++) begin
         w = $urandom;
         send_word(w, 0);
         if (i < 8) exp_q.push_back(w);
         if (i == 7) begin
            total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", overflow_o); end
         end
      end
      total++; if (occupancy_o !== 4'd8) begin bad++; $display("FAIL ovf_occ: got %0d want 8", occupancy_o); end
      total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow_o); end
      core_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         e = exp_q.pop_front();
         total++; if (core_valid_o !== 1'b1 || core_data_o !== e) begin
            bad++; $display("FAIL ovf_drain%0d: got v=%b %h want v=1 %h", i, core_valid_o, core_data_o, e);
         end
         tick();
      end
      core_ready_i = 1'b0;
      total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL ovf_empty: got %b want 0", core_valid_o); end
      total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow_o); end
   endtask

   task automatic test_full_push_pop();
      logic [31:0] w, w9, e;
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         w = $urandom;
         send_word(w, 0);
         exp_q.push_back(w);
      end
      w9 = 32'hC0FFEE09;
      for (int k = 0; k < 3; k++) begin
         io_valid_i = 1'b1; io_data_i = w9[k*8 +: 8]; tick();
      end
      io_data_i    = w9[31:24];
      core_ready_i = 1'b1;
      e = exp_q.pop_front();
      total++; if (core_data_o !== e) begin bad++; $display("FAIL fpp_head: got %h want %h", core_data_o, e); end
      tick();
      io_valid_i = 1'b0; core_ready_i = 1'b0;
      exp_q.push_back(w9);
      total++; if (occupancy_o !== 4'd8) begin bad++; $display("FAIL fpp_occ: got %0d want 8", occupancy_o); end
      total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL fpp_ovf: got %b want 0", overflow_o); end
      core_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         e = exp_q.pop_front();
         total++; if (core_valid_o !== 1'b1 || core_data_o !== e) begin
            bad++; $display("FAIL fpp_drain%0d: got v=%b %h want v=1 %h", i, core_valid_o, core_data_o, e);
         end
         tick();
      end
      core_ready_i = 1'b0;
      total++; if (occupancy_o !== 4'd0) begin bad++; $display("FAIL fpp_empty: got %0d want 0", occupancy_o); end
   endtask

   task automatic test_token();
      logic [31:0] wv[6];
      logic [31:0] e;
      int pops = 0;
      apply_reset();
      foreach (wv[i]) wv[i] = $urandom;
      core_ready_i = 1'b1;
      for (int c = 0; c < 28; c++) begin
         if (c < 24) begin
            io_valid_i = 1'b1;
            io_data_i  = wv[c/4][(c%4)*8 +: 8];
            if (c % 4 == 3) exp_q.push_back(wv[c/4]);
         end else io_valid_i = 1'b0;
         if (core_valid_o) begin
            e = exp_q.pop_front();
            pops++;
            total++; if (core_data_o !== e) begin bad++; $display("FAIL tok_data%0d: got %h want %h", pops, core_data_o, e); end
         end
         tick();
         total++; if (io_token_r_o !== 1'((pops >> 1) & 1)) begin
            bad++; $display("FAIL tok_c%0d: got %b want %b after %0d pops", c, io_token_r_o, 1'((pops >> 1) & 1), pops);
         end
      end
      io_valid_i = 1'b0;
      total++; if (pops != 6) begin bad++; $display("FAIL tok_pops: got %0d want 6", pops); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] w = 32'hDEADBEEF;
      core_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) send_word($urandom, 0);
      for (int k = 0; k < 2; k++) begin
         io_valid_i = 1'b1; io_data_i = 8'h5A; tick();
      end
      io_valid_i = 1'b0;
      rst_n = 1'b0;
      tick();
      total++; if (core_valid_o !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", core_valid_o); end
      total++; if (core_data_o !== 32'h0) begin bad++; $display("FAIL rmid_data: got %h want 0", core_data_o); end
      total++; if (io_token_r_o !== 1'b0) begin bad++; $display("FAIL rmid_token: got %b want 0", io_token_r_o); end
      total++; if (occupancy_o !== 4'd0) begin bad++; $display("FAIL rmid_occ: got %0d want 0", occupancy_o); end
      total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL rmid_ovf: got %b want 0", overflow_o); end
      rst_n = 1'b1;
      exp_q.delete();
      send_word(w, 0);
      exp_q.push_back(w);
      total++; if (core_valid_o !== 1'b1) begin bad++; $display("FAIL rmid_new_valid: got %b want 1", core_valid_o); end
      total++; if (core_data_o !== exp_q[0]) begin bad++; $display("FAIL rmid_new_data: got %h want %h", core_data_o, exp_q[0]); end
      total++; if (occupancy_o !== 4'd1) begin bad++; $display("FAIL rmid_new_occ: got %0d want 1", occupancy_o); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_overflow();
      test_full_push_pop();
      test_token();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
